// File: rtl/count_reporter_if.sv
// Signal bundle between the count source / AVR side and count_reporter.
// master = environment driving count and avr_rx_busy; slave = the reporter.
interface count_reporter_if;
   logic [7:0] count;
   logic       avr_rx_busy;
   logic       tx;
   logic       busy;

   modport master (output count, avr_rx_busy, input tx, busy);
   modport slave  (input count, avr_rx_busy, output tx, busy);
endinterface

// File: rtl/count_reporter.sv
// Sends each new count value as an ASCII hex line ("XX\r\n") over an 8N1 UART,
// coalescing changes that occur while a frame is in flight.
module count_reporter #(
   parameter int CLK_PER_BIT = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   count_reporter_if.slave bus
);

   localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HOLD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t                 state_q, state_n;
   logic [7:0]             last_sent_q, last_sent_n;
   logic [7:0]             frame_val_q, frame_val_n;
   logic [1:0]             byte_idx_q, byte_idx_n;
   logic [2:0]             bit_idx_q, bit_idx_n;
   logic [CNT_W-1:0]       cyc_q, cyc_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_blk;
   logic [7:0]             cur_byte;
   logic                   bit_done;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign rx_blk   = sync_q[SYNC_STAGES-1];
   assign bit_done = (cyc_q == CNT_LAST);

   always_comb begin
      case (byte_idx_q)
         2'd0:    cur_byte = hex_ascii(frame_val_q[7:4]);
         2'd1:    cur_byte = hex_ascii(frame_val_q[3:0]);
         2'd2:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // NOTE: every signal gets a default before the case so no branch can leave it
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_n     = state_q;
      last_sent_n = last_sent_q;
      frame_val_n = frame_val_q;
      byte_idx_n  = byte_idx_q;
      bit_idx_n   = bit_idx_q;
      cyc_n       = cyc_q;
      case (state_q)
         IDLE: begin
            if (bus.count != last_sent_q) begin
               frame_val_n = bus.count;
               last_sent_n = bus.count;
               byte_idx_n  = 2'd0;
               state_n     = HOLD;
            end
         end
         HOLD: begin
            if (!rx_blk) begin
               cyc_n   = '0;
               state_n = START;
            end
         end
         START: begin
            cyc_n = cyc_q + 1'b1;
            if (bit_done) begin
               cyc_n     = '0;
               bit_idx_n = 3'd0;
               state_n   = DATA;
            end
         end
         DATA: begin
            cyc_n = cyc_q + 1'b1;
            if (bit_done) begin
               cyc_n     = '0;
               bit_idx_n = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            cyc_n = cyc_q + 1'b1;
            if (bit_done) begin
               cyc_n = '0;
               if (byte_idx_q == 2'd3) begin
                  state_n = IDLE;
               end else begin
                  byte_idx_n = byte_idx_q + 2'd1;
                  state_n    = HOLD;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.tx = 1'b1;
      if (state_q == START)     bus.tx = 1'b0;
      else if (state_q == DATA) bus.tx = cur_byte[bit_idx_q];
   end

   assign bus.busy = (state_q != IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_sent_q <= 8'h00;
         frame_val_q <= 8'h00;
         byte_idx_q  <= 2'd0;
         bit_idx_q   <= 3'd0;
         cyc_q       <= '0;
         sync_q      <= '0;
      end else begin
         state_q     <= state_n;
         last_sent_q <= last_sent_n;
         frame_val_q <= frame_val_n;
         byte_idx_q  <= byte_idx_n;
         bit_idx_q   <= bit_idx_n;
         cyc_q       <= cyc_n;
         sync_q      <= (sync_q << 1) | SYNC_STAGES'(bus.avr_rx_busy);
      end
   end

endmodule

// File: tb/tb_count_reporter.sv
// Scoreboard bench for count_reporter: a timeline model predicts frames and busy,
// a UART monitor decodes tx and checks bit widths and bytes against the queue.
module tb_count_reporter;

   localparam int CPB  = 4;
   localparam int SYNC = 2;
   localparam int NFR  = 40 * CPB + 4;   // busy cycles of one frame with no blocking

   logic clk = 1'b0;
   logic rst_n;
   count_reporter_if ifc ();

   count_reporter #(.CLK_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int busy_end = 0;
   int m_latch  = 0;
   logic [7:0] m_last = 8'h00;
   logic [7:0] exp_q[$];
   int start_log[$];
   string hx = "0123456789ABCDEF";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: an idle reporter seeing count != last value starts a frame
   // whose bytes are the uppercase hex text plus CR LF, busy for NFR cycles.
   task automatic model_eval();
      logic [7:0] c;
      c = ifc.count;
      if (cyc >= busy_end && c != m_last) begin
         exp_q.push_back(8'(hx[c[7:4]]));
         exp_q.push_back(8'(hx[c[3:0]]));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         m_last   = c;
         m_latch  = cyc + 1;
         busy_end = cyc + 1 + NFR;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step(input logic [7:0] c);
      tick();
      check("busy", {31'd0, ifc.busy}, {31'd0, (cyc < busy_end)});
      if (cyc >= busy_end) check("idle_tx", {31'd0, ifc.tx}, 32'd1);
      ifc.count = c;
      model_eval();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(cyc > busy_end + 1) && n < budget) begin
         step(ifc.count);
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_idle: budget %0d cycles expired, busy_end %0d", budget, busy_end);
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic pulse_reset();
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      check("rst_busy", {31'd0, ifc.busy}, 32'd0);
      check("rst_tx", {31'd0, ifc.tx}, 32'd1);
      rst_n    = 1'b1;
      m_last   = 8'h00;
      busy_end = cyc;
      model_eval();
   endtask

   // UART monitor: samples tx once per cycle on the falling edge.
   initial begin : monitor
      logic smp[10*CPB];
      int   pos;
      bit   cap;
      logic [7:0] data;
      logic       width_ok;
      cap = 1'b0;
      pos = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            cap = 1'b0;
         end else if (!cap) begin
            if (ifc.tx === 1'b0) begin
               cap = 1'b1;
               smp[0] = 1'b0;
               pos = 1;
               start_log.push_back(cyc);
            end
         end else begin
            smp[pos] = ifc.tx;
            pos++;
            if (pos == 10 * CPB) begin
               cap = 1'b0;
               width_ok = 1'b1;
               for (int i = 0; i < 10 * CPB; i++)
                  if (smp[i] !== smp[(i / CPB) * CPB]) width_ok = 1'b0;
               for (int b = 0; b < 8; b++) data[b] = smp[(b + 1) * CPB];
               check("bit_width", {31'd0, width_ok}, 32'd1);
               check("stop_bit", {31'd0, smp[9*CPB]}, 32'd1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL tx_byte: unexpected byte %h, nothing expected", data);
               end else begin
                  check("tx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int r;
      rst_n = 1'b0;
      ifc.count = 8'h00;
      ifc.avr_rx_busy = 1'b0;
      repeat (3) tick();
      check("reset_busy", {31'd0, ifc.busy}, 32'd0);
      check("reset_tx", {31'd0, ifc.tx}, 32'd1);
      rst_n = 1'b1;
      busy_end = cyc;
      model_eval();

      // count 0 after reset: nothing to send
      repeat (20) step(8'h00);
      check("no_frame_zero", exp_q.size(), 0);

      // basic frame "A5\r\n"
      step(8'hA5);
      wait_idle(400);

      // intermediate value dropped: "01" then "03"
      repeat (30) step(8'h01);
      repeat (30) step(8'h02);
      step(8'h03);
      wait_idle(800);

      // value returns before frame ends: only "10"
      repeat (30) step(8'h10);
      repeat (40) step(8'h11);
      step(8'h10);
      wait_idle(800);
      check("no_refire", {31'd0, ifc.busy}, 32'd0);

      // receiver blocked during first stop bit, released 50 cycles later
      start_log.delete();
      step(8'hFF);
      while (cyc < m_latch + 1 + 9 * CPB) step(8'hFF);
      ifc.avr_rx_busy = 1'b1;
      repeat (50) step(8'hFF);
      ifc.avr_rx_busy = 1'b0;
      r = cyc;
      busy_end = busy_end + (r + 1 + SYNC) - (m_latch + 10 * CPB + 2);
      wait_idle(800);
      check("start_count", start_log.size(), 4);
      if (start_log.size() >= 2) check("unblock_delay", start_log[1], r + 1 + SYNC);

      // reset during DATA of byte 1, then a fresh full frame
      step(8'h3C);
      while (cyc < m_latch + 12 * CPB + 1) step(8'h3C);
      pulse_reset();
      wait_idle(800);

      // randomized count activity
      for (int s = 0; s < 14; s++) begin
         logic [7:0] v;
         int dur;
         v   = ($urandom_range(0, 3) == 0) ? m_last : 8'($urandom);
         dur = $urandom_range(1, 220);
         repeat (dur) step(v);
      end
      wait_idle(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
